alu_issue_stage: RTL and testbench

Execute-stage issue register that sits directly upstream of the 32-bit ALU in the RISC-V pipeline. It accepts decoded instructions from the decode stage over a valid/ready handshake and derives the 3-bit ALU control code and operand B selection from opcode/funct fields. It registers the ALU operands and control into a two-entry skid buffer, so ALU-side back-pressure never creates a combinational ready path into decode.

---
 rtl/alu_issue_stage.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage issue register in front of the 32-bit ALU.
// Decodes opcode/funct fields into a 3-bit ALU control code and an operand-B
// select, then holds the result in a two-entry skid buffer (main M, skid S).
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds its payload stable while
// valid && !ready. in_ready comes straight from the state register, so
// out_ready never reaches in_ready combinationally.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int RDW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [RDW-1:0]   rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  output logic [RDW-1:0]   rd_out,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_AND = 3'b010;
  localparam logic [2:0] C_OR  = 3'b011;
  localparam logic [2:0] C_SLT = 3'b101;

  // Entry layout: {illegal, alu_cntrl, rd, alu_b, alu_a}
  localparam int EW = 2*WIDTH + RDW + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   m_q, s_q;
  logic [EW-1:0]   in_entry;
  logic [2:0]      dec_ctrl;
  logic            dec_use_imm;
  logic            dec_ill;
  logic            accept;
  logic            load_m_in, load_m_s, load_s;

  // Decode the incoming instruction fields into control, operand select and
  // the illegal flag. Unsupported encodings still flow as add with rs2.
  always_comb begin
    dec_ctrl    = C_ADD;
    dec_use_imm = 1'b0;
    dec_ill     = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: dec_use_imm = 1'b1;
      OP_BRANCH:         dec_ctrl    = C_SUB;
      OP_RTYPE, OP_ITYPE: begin
        dec_use_imm = (opcode == OP_ITYPE);
        case (funct3)
          3'b000:  dec_ctrl = (opcode == OP_RTYPE && funct7b5) ? C_SUB : C_ADD;
          3'b010:  dec_ctrl = C_SLT;
          3'b110:  dec_ctrl = C_OR;
          3'b111:  dec_ctrl = C_AND;
          default: begin
            dec_ill     = 1'b1;
            dec_use_imm = 1'b0;
          end
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_entry = {dec_ill, dec_ctrl, rd_in,
                     (dec_use_imm ? imm : rs2_data), rs1_data};

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state_q;

  assign alu_a     = m_q[WIDTH-1:0];
  assign alu_b     = m_q[2*WIDTH-1:WIDTH];
  assign rd_out    = m_q[2*WIDTH+RDW-1:2*WIDTH];
  assign alu_cntrl = m_q[2*WIDTH+RDW+2:2*WIDTH+RDW];
  assign illegal   = m_q[EW-1];

  // Next state and buffer load enables; flush wins over accept and drain.
  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          state_d = FULL;
          load_s  = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d  = ONE;
          load_m_s = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Main and skid entry registers; S moves into M when M drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in)     m_q <= in_entry;
      else if (load_m_s) m_q <= s_q;
      if (load_s)        s_q <= in_entry;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode cases, back-pressure, flush,
// asynchronous reset mid-stream, then a random stream with random out_ready.
module tb_alu_issue_stage;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        flush, in_valid, in_ready, funct7b5, out_valid, out_ready, illegal;
  logic [6:0]  opcode;
  logic [2:0]  funct3, alu_cntrl;
  logic [31:0] rs1_data, rs2_data, imm, alu_a, alu_b;
  logic [4:0]  rd_in, rd_out;
  logic [1:0]  state_dbg;

  alu_issue_stage #(.WIDTH(32), .RDW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .rd_out(rd_out), .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [72:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit rand_mode = 1'b0;

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction table.
  function automatic logic [72:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] im,
                                        input logic [4:0] rd);
    logic [2:0]  c;
    logic        ill;
    logic [31:0] ob;
    c = 3'b000; ill = 1'b0; ob = b;
    if (op == OP_LOAD || op == OP_STORE) ob = im;
    else if (op == OP_BRANCH) c = 3'b001;
    else if (op == OP_RTYPE || op == OP_ITYPE) begin
      if (op == OP_ITYPE) ob = im;
      if (f3 == 3'b000)      c = (op == OP_RTYPE && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) c = 3'b101;
      else if (f3 == 3'b110) c = 3'b011;
      else if (f3 == 3'b111) c = 3'b010;
      else begin ill = 1'b1; ob = b; end
    end else ill = 1'b1;
    return {ill, c, rd, ob, a};
  endfunction

  // Observes both handshakes on the falling edge, when inputs and outputs
  // are settled for the upcoming rising edge.
  task automatic monitor();
    logic [72:0] e;
    forever begin
      @(negedge clk);
      if (rst) exp_q.delete();
      else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("sb_underflow", 73'(0), 73'(1));
          else begin
            e = exp_q.pop_front();
            check("sb_entry", {illegal, alu_cntrl, rd_out, alu_b, alu_a}, e);
          end
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready)
          exp_q.push_back(model(opcode, funct3, funct7b5, rs1_data, rs2_data, imm, rd_in));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] rd);
    opcode = op; funct3 = f3; funct7b5 = f7;
    rs1_data = a; rs2_data = b; imm = im; rd_in = rd;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [4:0] rd);
    bit got;
    got = 1'b0;
    present(op, f3, f7, a, b, im, rd);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
    if (!got) check("accept_timeout", 73'(0), 73'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) begin done = 1'b1; break; end
    end
    check("drain_done", 73'(done), 73'(1));
    check("sb_left", 73'(exp_q.size()), 73'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ov"},  73'(out_valid), 73'(0));
    check({tag, "_ir"},  73'(in_ready),  73'(1));
    check({tag, "_a"},   73'(alu_a),     73'(0));
    check({tag, "_b"},   73'(alu_b),     73'(0));
    check({tag, "_c"},   73'(alu_cntrl), 73'(0));
    check({tag, "_rd"},  73'(rd_out),    73'(0));
    check({tag, "_ill"}, 73'(illegal),   73'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] ops [7];
  logic [2:0] f3s [6];
  logic [31:0] held_a;

  initial begin
    ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_ITYPE, OP_BAD, 7'b0110111};
    f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b100};
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; rd_in = '0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Basic R-type sub
    out_ready = 1'b1;
    send(OP_RTYPE, 3'b000, 1'b1, 32'd10, 32'd3, 32'd99, 5'd7);
    check("r_sub_ov",  73'(out_valid), 73'(1));
    check("r_sub_c",   73'(alu_cntrl), 73'(3'b001));
    check("r_sub_a",   73'(alu_a),     73'(10));
    check("r_sub_b",   73'(alu_b),     73'(3));
    check("r_sub_ill", 73'(illegal),   73'(0));

    // I-type variants; funct7b5 must not turn addi into sub
    send(OP_ITYPE, 3'b000, 1'b1, 32'd5, 32'd8, 32'hFFFF_FFFF, 5'd1);
    check("i_add_c", 73'(alu_cntrl), 73'(3'b000));
    check("i_add_b", 73'(alu_b),     73'(32'hFFFF_FFFF));
    send(OP_ITYPE, 3'b010, 1'b0, 32'd5, 32'd8, 32'hFFFF_FFFF, 5'd2);
    check("i_slt_c", 73'(alu_cntrl), 73'(3'b101));
    send(OP_ITYPE, 3'b110, 1'b0, 32'd5, 32'd8, 32'hFFFF_FFFF, 5'd3);
    check("i_or_c",  73'(alu_cntrl), 73'(3'b011));
    send(OP_ITYPE, 3'b111, 1'b0, 32'd5, 32'd8, 32'hFFFF_FFFF, 5'd4);
    check("i_and_c", 73'(alu_cntrl), 73'(3'b010));

    // Illegal encodings
    send(OP_BAD, 3'b000, 1'b0, 32'd1, 32'h1234, 32'h55, 5'd5);
    check("bad_ill", 73'(illegal),   73'(1));
    check("bad_c",   73'(alu_cntrl), 73'(0));
    check("bad_b",   73'(alu_b),     73'(32'h1234));
    send(OP_RTYPE, 3'b001, 1'b0, 32'd1, 32'h4321, 32'h55, 5'd6);
    check("r001_ill", 73'(illegal), 73'(1));
    drain();

    // Back-pressure: A held, B into skid, C waits
    out_ready = 1'b0;
    send(OP_LOAD,   3'b010, 1'b0, 32'hA, 32'h1, 32'h100, 5'd10);
    send(OP_BRANCH, 3'b000, 1'b0, 32'hB, 32'h2, 32'h200, 5'd11);
    present(OP_RTYPE, 3'b110, 1'b0, 32'hC, 32'h3, 32'h300, 5'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ir",    73'(in_ready),  73'(0));
      check("bp_ov",    73'(out_valid), 73'(1));
      check("bp_hold",  73'(alu_a),     73'(32'hA));
      check("bp_state", 73'(state_dbg), 73'(2));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_RTYPE, 3'b110, 1'b0, 32'hC, 32'h3, 32'h300, 5'd12);
    drain();
    check("bp_ir_back", 73'(in_ready), 73'(1));

    // Flush while FULL with a simultaneous input
    out_ready = 1'b0;
    send(OP_STORE, 3'b000, 1'b0, 32'h11, 32'h1, 32'h2, 5'd13);
    send(OP_RTYPE, 3'b111, 1'b0, 32'h22, 32'h1, 32'h2, 5'd14);
    present(OP_ITYPE, 3'b000, 1'b0, 32'h33, 32'h1, 32'h2, 5'd15);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl_ov", 73'(out_valid), 73'(0));
    check("fl_ir", 73'(in_ready),  73'(1));
    check("fl_sb", 73'(exp_q.size()), 73'(0));
    @(posedge clk); #1;
    drain();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(OP_RTYPE, 3'b000, 1'b0, 32'h44, 32'h5, 32'h6, 5'd16);
    send(OP_RTYPE, 3'b010, 1'b0, 32'h55, 32'h5, 32'h6, 5'd17);
    #2 rst = 1'b1;
    #1 check_zero_outputs("arst");
    check("arst_state", 73'(state_dbg), 73'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(OP_ITYPE, 3'b111, 1'b0, 32'h66, 32'h5, 32'h77, 5'd18);
    check("arst_resume_ov", 73'(out_valid), 73'(1));
    check("arst_resume_a",  73'(alu_a),     73'(32'h66));
    drain();

    // Random stream with random back-pressure
    rand_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send(ops[$urandom_range(0, 6)], f3s[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
           $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    end
    rand_mode = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
